// File: rtl/pic_bus_command_sequencer.sv
// Bus front end for the PIC: synchronises the host strobes, captures write
// data and turns each completed write into one registered command strobe,
// while tracking the ICW1..ICW4 initialisation sequence.
module pic_bus_command_sequencer #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  chip_select,
   input  logic                  read_enable,
   input  logic                  write_enable,
   input  logic                  A0,
   input  logic [DATA_WIDTH-1:0] data_bus_input,
   output logic [DATA_WIDTH-1:0] internal_data_bus,
   output logic                  write_ICW1,
   output logic                  write_ICW2,
   output logic                  write_ICW3,
   output logic                  write_ICW4,
   output logic                  write_OCW1,
   output logic                  write_OCW2,
   output logic                  write_OCW3,
   output logic                  read,
   output logic                  read_start,
   output logic                  init_done,
   output logic                  single_mode,
   output logic                  icw4_needed,
   output logic                  level_triggered,
   output logic                  protocol_error
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ICW2,
      WAIT_ICW3,
      WAIT_ICW4,
      READY
   } stateT;

   // Synchronised pins, packed as {chip_select, read_enable, write_enable, A0}.
   // Data rides a matching delay line so it stays aligned with the strobes.
   logic [3:0]            w_pinsSync;
   logic [DATA_WIDTH-1:0] w_dataSync;

   generate
      if (SYNC_STAGES == 0) begin : gDirect
         assign w_pinsSync = {chip_select, read_enable, write_enable, A0};
         assign w_dataSync = data_bus_input;
      end else begin : gSync
         logic [3:0]            r_pinPipe  [SYNC_STAGES];
         logic [DATA_WIDTH-1:0] r_dataPipe [SYNC_STAGES];

         // Shift pins and data through the synchroniser; reset parks strobes inactive
         always_ff @(posedge clock) begin
            if (reset) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  r_pinPipe[i]  <= 4'b1110;
                  r_dataPipe[i] <= '0;
               end
            end else begin
               r_pinPipe[0]  <= {chip_select, read_enable, write_enable, A0};
               r_dataPipe[0] <= data_bus_input;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  r_pinPipe[i]  <= r_pinPipe[i-1];
                  r_dataPipe[i] <= r_dataPipe[i-1];
               end
            end
         end

         assign w_pinsSync = r_pinPipe[SYNC_STAGES-1];
         assign w_dataSync = r_dataPipe[SYNC_STAGES-1];
      end
   endgenerate

   logic w_csActive;
   logic w_rdActive;
   logic w_wrActive;
   logic w_a0Sync;
   assign w_csActive = ~w_pinsSync[3];
   assign w_rdActive = ~w_pinsSync[2];
   assign w_wrActive = ~w_pinsSync[1];
   assign w_a0Sync   =  w_pinsSync[0];

   stateT                 r_state;
   stateT                 w_nextState;
   logic [1:0]            r_settleCount;
   logic                  w_settled;
   logic                  r_wrQuiet;
   logic                  r_armed;
   logic                  r_a0Latch;
   logic [DATA_WIDTH-1:0] r_dataLatch;
   logic [DATA_WIDTH-1:0] r_intData;
   logic [6:0]            r_cmdStrobe;
   logic [6:0]            w_cmd;
   logic                  w_cmdError;
   logic                  w_commit;
   logic                  w_overlap;
   logic                  w_readLevel;
   logic                  r_overlapPrev;
   logic                  r_read;
   logic                  r_readStart;
   logic                  r_protoErr;
   logic                  r_singleMode;
   logic                  r_icw4Needed;
   logic                  r_levelTriggered;

   // The synchroniser output is trustworthy only once it has refilled after reset
   assign w_settled   = (r_settleCount == 2'(SYNC_STAGES));
   assign w_commit    = r_armed & ~w_wrActive;
   assign w_overlap   = w_csActive & w_rdActive & w_wrActive;
   assign w_readLevel = w_csActive & w_rdActive & ~w_wrActive;

   // Count refill cycles after reset, then remember that write_enable was seen idle
   always_ff @(posedge clock) begin
      if (reset) begin
         r_settleCount <= '0;
         r_wrQuiet     <= 1'b0;
      end else begin
         if (!w_settled) r_settleCount <= r_settleCount + 2'd1;
         if (w_settled && !w_wrActive) r_wrQuiet <= 1'b1;
      end
   end

   // Arm on a selected write, drop it if chip_select leaves early, clear on commit
   always_ff @(posedge clock) begin
      if (reset) begin
         r_armed     <= 1'b0;
         r_a0Latch   <= 1'b0;
         r_dataLatch <= '0;
      end else begin
         if (w_commit) begin
            r_armed <= 1'b0;
         end else if (w_csActive && w_wrActive && r_wrQuiet) begin
            r_armed <= 1'b1;
         end else if (!w_csActive && w_wrActive) begin
            r_armed <= 1'b0;
         end
         if (w_csActive && w_wrActive) begin
            r_a0Latch   <= w_a0Sync;
            r_dataLatch <= w_dataSync;
         end
      end
   end

   // Initialisation sequence state register
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // Decode a committed write into one command (bit 0 = ICW1 .. bit 6 = OCW3) and the next state
   always_comb begin
      w_nextState = r_state;
      w_cmd       = '0;
      w_cmdError  = 1'b0;
      if (w_commit) begin
         if (!r_a0Latch && r_dataLatch[4]) begin
            w_cmd[0]    = 1'b1;
            w_nextState = WAIT_ICW2;
         end else if (r_a0Latch) begin
            case (r_state)
               WAIT_ICW2: begin
                  w_cmd[1] = 1'b1;
                  if (!r_singleMode)     w_nextState = WAIT_ICW3;
                  else if (r_icw4Needed) w_nextState = WAIT_ICW4;
                  else                   w_nextState = READY;
               end
               WAIT_ICW3: begin
                  w_cmd[2]    = 1'b1;
                  w_nextState = r_icw4Needed ? WAIT_ICW4 : READY;
               end
               WAIT_ICW4: begin
                  w_cmd[3]    = 1'b1;
                  w_nextState = READY;
               end
               READY:   w_cmd[4]   = 1'b1;
               default: w_cmdError = 1'b1;
            endcase
         end else if (r_state == READY) begin
            if (r_dataLatch[3]) w_cmd[6] = 1'b1;
            else                w_cmd[5] = 1'b1;
         end else begin
            w_cmdError = 1'b1;
         end
      end
   end

   // Register strobes, read tracking, error pulse, ICW1 mode bits and the data bus
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cmdStrobe      <= '0;
         r_protoErr       <= 1'b0;
         r_overlapPrev    <= 1'b0;
         r_read           <= 1'b0;
         r_readStart      <= 1'b0;
         r_intData        <= '0;
         r_singleMode     <= 1'b0;
         r_icw4Needed     <= 1'b0;
         r_levelTriggered <= 1'b0;
      end else begin
         r_cmdStrobe   <= w_cmd;
         r_protoErr    <= w_cmdError | (w_overlap & ~r_overlapPrev);
         r_overlapPrev <= w_overlap;
         r_read        <= w_readLevel;
         r_readStart   <= w_readLevel & ~r_read;
         if (w_commit) r_intData <= r_dataLatch;
         if (w_cmd[0]) begin
            r_singleMode     <= r_dataLatch[1];
            r_icw4Needed     <= r_dataLatch[0];
            r_levelTriggered <= r_dataLatch[3];
         end
      end
   end

   assign internal_data_bus = r_intData;
   assign write_ICW1        = r_cmdStrobe[0];
   assign write_ICW2        = r_cmdStrobe[1];
   assign write_ICW3        = r_cmdStrobe[2];
   assign write_ICW4        = r_cmdStrobe[3];
   assign write_OCW1        = r_cmdStrobe[4];
   assign write_OCW2        = r_cmdStrobe[5];
   assign write_OCW3        = r_cmdStrobe[6];
   assign read              = r_read;
   assign read_start        = r_readStart;
   assign init_done         = (r_state == READY);
   assign single_mode       = r_singleMode;
   assign icw4_needed       = r_icw4Needed;
   assign level_triggered   = r_levelTriggered;
   assign protocol_error    = r_protoErr;

endmodule

// File: tb/tb_pic_bus_command_sequencer.sv
// Scoreboarded bench for pic_bus_command_sequencer: each driven write pushes
// the strobe, data and cycle it should produce; a monitor pops and compares.
module tb_pic_bus_command_sequencer;

   localparam int DATA_WIDTH  = 8;
   localparam int SYNC_STAGES = 2;

   // Event codes: bit 0..6 = ICW1..OCW3, bit 7 = protocol_error
   localparam logic [7:0] EV_ICW1 = 8'h01;
   localparam logic [7:0] EV_ICW2 = 8'h02;
   localparam logic [7:0] EV_ICW3 = 8'h04;
   localparam logic [7:0] EV_ICW4 = 8'h08;
   localparam logic [7:0] EV_OCW1 = 8'h10;
   localparam logic [7:0] EV_OCW2 = 8'h20;
   localparam logic [7:0] EV_OCW3 = 8'h40;
   localparam logic [7:0] EV_ERR  = 8'h80;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic                  chipSelect = 1'b1;
   logic                  readEnable = 1'b1;
   logic                  writeEnable = 1'b1;
   logic                  a0 = 1'b0;
   logic [DATA_WIDTH-1:0] dataBusInput = '0;
   logic [DATA_WIDTH-1:0] internalDataBus;
   logic writeIcw1, writeIcw2, writeIcw3, writeIcw4;
   logic writeOcw1, writeOcw2, writeOcw3;
   logic readLevel, readStart, initDone, singleMode, icw4Needed, levelTriggered, protocolError;

   typedef struct {
      int                    expCycle;
      logic [7:0]            code;
      logic [DATA_WIDTH-1:0] data;
      bit                    checkData;
   } expT;

   expT sbQueue[$];
   int  cycleCount = 0;
   int  eventCount = 0;
   int  readHighCount = 0;
   int  readStartCount = 0;
   int  checkCount = 0;
   int  failCount = 0;

   pic_bus_command_sequencer #(
      .DATA_WIDTH (DATA_WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .chip_select      (chipSelect),
      .read_enable      (readEnable),
      .write_enable     (writeEnable),
      .A0               (a0),
      .data_bus_input   (dataBusInput),
      .internal_data_bus(internalDataBus),
      .write_ICW1       (writeIcw1),
      .write_ICW2       (writeIcw2),
      .write_ICW3       (writeIcw3),
      .write_ICW4       (writeIcw4),
      .write_OCW1       (writeOcw1),
      .write_OCW2       (writeOcw2),
      .write_OCW3       (writeOcw3),
      .read             (readLevel),
      .read_start       (readStart),
      .init_done        (initDone),
      .single_mode      (singleMode),
      .icw4_needed      (icw4Needed),
      .level_triggered  (levelTriggered),
      .protocol_error   (protocolError)
   );

   // Free-running clock and a cycle counter used to time the strobes
   always #5 clock = ~clock;
   always @(posedge clock) cycleCount++;

   // Give up loudly if the stimulus ever stalls
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at cycle %0d", tag, observed, expected, cycleCount);
      end
   endtask

   function automatic logic [22:0] packOutputs();
      return {internalDataBus, writeIcw1, writeIcw2, writeIcw3, writeIcw4, writeOcw1, writeOcw2,
              writeOcw3, readLevel, readStart, initDone, singleMode, icw4Needed, levelTriggered,
              protocolError};
   endfunction

   // Monitor just after each rising edge: pop and compare every strobe, count read activity
   always begin
      logic [7:0] obs;
      expT        e;
      @(posedge clock);
      #1;
      obs = {protocolError, writeOcw3, writeOcw2, writeOcw1, writeIcw4, writeIcw3, writeIcw2, writeIcw1};
      if (readLevel) readHighCount++;
      if (readStart) readStartCount++;
      if (obs != 8'h00) begin
         eventCount++;
         if (sbQueue.size() == 0) begin
            checkOutput("unexpectedEvent", 32'(obs), 32'h0);
         end else begin
            e = sbQueue.pop_front();
            checkOutput("eventCode", 32'(obs), 32'(e.code));
            checkOutput("eventLatency", cycleCount, e.expCycle);
            if (e.checkData) checkOutput("internalData", 32'(internalDataBus), 32'(e.data));
         end
      end
   end

   task automatic pushExpect(input logic [7:0] code, input logic [DATA_WIDTH-1:0] data, input bit checkData);
      expT e;
      e.expCycle  = cycleCount + SYNC_STAGES + 1;
      e.code      = code;
      e.data      = data;
      e.checkData = checkData;
      sbQueue.push_back(e);
   endtask

   // One complete host write; the expectation is queued at the write_enable rise
   task automatic applyStimulus(input logic addr, input logic [DATA_WIDTH-1:0] data,
                                input logic [7:0] code, input bit checkData);
      @(negedge clock);
      a0           = addr;
      dataBusInput = data;
      chipSelect   = 1'b0;
      writeEnable  = 1'b0;
      repeat (3) @(negedge clock);
      writeEnable = 1'b1;
      pushExpect(code, data, checkData);
      repeat (SYNC_STAGES + 3) @(negedge clock);
      chipSelect = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic applyReset();
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (SYNC_STAGES + 2) @(negedge clock);
   endtask

   task automatic waitDrain(input string tag);
      int waited = 0;
      while (sbQueue.size() != 0 && waited < 40) begin
         @(negedge clock);
         waited++;
      end
      checkOutput(tag, sbQueue.size(), 0);
      sbQueue.delete();
   endtask

   initial begin
      int eventsBefore;
      $display("[TB] Starting pic_bus_command_sequencer bench");

      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (SYNC_STAGES + 2) @(negedge clock);
      checkOutput("resetOutputs", 32'(packOutputs()), 32'h0);

      // Single, ICW4 needed: ICW1, ICW2, ICW4
      applyStimulus(1'b0, 8'h13, EV_ICW1, 1'b1);
      checkOutput("singleIcw1InitDone", 32'(initDone), 32'h0);
      applyStimulus(1'b1, 8'h20, EV_ICW2, 1'b1);
      applyStimulus(1'b1, 8'h01, EV_ICW4, 1'b1);
      waitDrain("singleInitDrain");
      checkOutput("singleInitDone", 32'(initDone), 32'h1);
      checkOutput("singleModeBit", 32'(singleMode), 32'h1);
      checkOutput("icw4NeededBit", 32'(icw4Needed), 32'h1);
      checkOutput("ltimBitClear", 32'(levelTriggered), 32'h0);

      // Cascade, no ICW4: ICW1, ICW2, ICW3 then OCW1
      applyStimulus(1'b0, 8'h10, EV_ICW1, 1'b1);
      checkOutput("cascadeIcw1InitDone", 32'(initDone), 32'h0);
      applyStimulus(1'b1, 8'h08, EV_ICW2, 1'b1);
      applyStimulus(1'b1, 8'h04, EV_ICW3, 1'b1);
      waitDrain("cascadeInitDrain");
      checkOutput("cascadeInitDone", 32'(initDone), 32'h1);
      checkOutput("cascadeSingleMode", 32'(singleMode), 32'h0);
      checkOutput("cascadeIcw4Needed", 32'(icw4Needed), 32'h0);
      applyStimulus(1'b1, 8'hFF, EV_OCW1, 1'b1);

      // Operational commands, then re-initialisation from READY
      applyStimulus(1'b0, 8'h20, EV_OCW2, 1'b1);
      applyStimulus(1'b0, 8'h0B, EV_OCW3, 1'b1);
      applyStimulus(1'b0, 8'h1A, EV_ICW1, 1'b1);
      waitDrain("reinitDrain");
      checkOutput("reinitInitDone", 32'(initDone), 32'h0);
      checkOutput("ltimBitSet", 32'(levelTriggered), 32'h1);
      applyStimulus(1'b1, 8'h40, EV_ICW2, 1'b1);
      waitDrain("singleNoIcw4Drain");
      checkOutput("singleNoIcw4InitDone", 32'(initDone), 32'h1);

      // Overlapping read and write: one error pulse, no read, write still lands
      readHighCount  = 0;
      readStartCount = 0;
      @(negedge clock);
      a0           = 1'b1;
      dataBusInput = 8'h3C;
      chipSelect   = 1'b0;
      writeEnable  = 1'b0;
      readEnable   = 1'b0;
      pushExpect(EV_ERR, 8'h00, 1'b0);
      repeat (3) @(negedge clock);
      readEnable = 1'b1;
      repeat (2) @(negedge clock);
      writeEnable = 1'b1;
      pushExpect(EV_OCW1, 8'h3C, 1'b1);
      repeat (SYNC_STAGES + 3) @(negedge clock);
      chipSelect = 1'b1;
      waitDrain("overlapDrain");
      checkOutput("overlapReadHigh", readHighCount, 0);
      checkOutput("overlapReadStart", readStartCount, 0);

      // Plain read held for four cycles
      repeat (2) @(negedge clock);
      readHighCount  = 0;
      readStartCount = 0;
      chipSelect     = 1'b0;
      readEnable     = 1'b0;
      repeat (4) @(negedge clock);
      chipSelect = 1'b1;
      readEnable = 1'b1;
      repeat (SYNC_STAGES + 4) @(negedge clock);
      checkOutput("readHighCycles", readHighCount, 4);
      checkOutput("readStartPulses", readStartCount, 1);
      checkOutput("readKeepsState", 32'(initDone), 32'h1);

      // Write abandoned by chip_select rising first: nothing at all
      eventsBefore = eventCount;
      @(negedge clock);
      a0           = 1'b1;
      dataBusInput = 8'h77;
      chipSelect   = 1'b0;
      writeEnable  = 1'b0;
      repeat (3) @(negedge clock);
      chipSelect = 1'b1;
      repeat (4) @(negedge clock);
      writeEnable = 1'b1;
      repeat (SYNC_STAGES + 6) @(negedge clock);
      checkOutput("abortedWriteEvents", eventCount - eventsBefore, 0);

      // Illegal accesses from reset
      applyReset();
      checkOutput("resetAgainOutputs", 32'(packOutputs()), 32'h0);
      applyStimulus(1'b1, 8'h55, EV_ERR, 1'b0);
      waitDrain("idleA0Drain");
      checkOutput("idleA0InitDone", 32'(initDone), 32'h0);
      applyStimulus(1'b0, 8'h13, EV_ICW1, 1'b1);
      applyStimulus(1'b0, 8'h08, EV_ERR, 1'b0);
      applyStimulus(1'b1, 8'h20, EV_ICW2, 1'b1);
      applyStimulus(1'b1, 8'h01, EV_ICW4, 1'b1);
      waitDrain("waitStateErrDrain");
      checkOutput("recoveredInitDone", 32'(initDone), 32'h1);

      // Reset in the middle of a write discards it
      eventsBefore = eventCount;
      @(negedge clock);
      a0           = 1'b1;
      dataBusInput = 8'hA5;
      chipSelect   = 1'b0;
      writeEnable  = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (SYNC_STAGES + 2) @(negedge clock);
      writeEnable = 1'b1;
      repeat (SYNC_STAGES + 6) @(negedge clock);
      chipSelect = 1'b1;
      repeat (SYNC_STAGES + 2) @(negedge clock);
      checkOutput("resetMidWriteEvents", eventCount - eventsBefore, 0);
      checkOutput("resetMidWriteOutputs", 32'(packOutputs()), 32'h0);

      checkOutput("finalQueueEmpty", sbQueue.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/pic_bus_command_sequencer.md
Name: pic_bus_command_sequencer

Overview:
- Clocked, parametrised successor to the PIC's combinational data-bus buffer and read/write decode.
- Synchronises the host bus strobes and latches bus data on the write pulse. Decodes each completed write into exactly one single-cycle command strobe.
- Tracks the full ICW1→ICW2→[ICW3]→[ICW4] initialisation sequence in a state machine, so ICW2, ICW3 and ICW4 get distinct strobes. Feeds the control logic, IRR/ISR/IMR registers and the cascade block.

Parameters:
DATA_WIDTH, 8, width of data_bus_input and internal_data_bus; command decode uses bits [7:0] only; must be ≥ 8
SYNC_STAGES, 2, synchroniser flops on chip_select/read_enable/write_enable/A0 (0 = sample directly, max 3)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
chip_select  input  1  active-low chip select
read_enable  input  1  active-low read strobe
write_enable  input  1  active-low write strobe
A0  input  1  register address bit
data_bus_input  input  DATA_WIDTH  host data bus
internal_data_bus  output  DATA_WIDTH  data latched from the most recent committed write
write_ICW1  output  1  1-cycle pulse
write_ICW2  output  1  1-cycle pulse
write_ICW3  output  1  1-cycle pulse
write_ICW4  output  1  1-cycle pulse
write_OCW1  output  1  1-cycle pulse
write_OCW2  output  1  1-cycle pulse
write_OCW3  output  1  1-cycle pulse
read  output  1  level: synchronised chip_select low and read_enable low, write not active
read_start  output  1  1-cycle pulse on the rising edge of read
init_done  output  1  high in state READY
single_mode  output  1  ICW1 D1 (SNGL), captured at ICW1
icw4_needed  output  1  ICW1 D0 (IC4), captured at ICW1
level_triggered  output  1  ICW1 D3 (LTIM), captured at ICW1
protocol_error  output  1  1-cycle pulse on an illegal or ignored access

Behaviour:
- Reset, held one or more cycles:
  - All outputs are 0; internal_data_bus is 0.
  - FSM goes to IDLE; the synchroniser stages and the armed flag clear.
  - Reset mid-write discards the write; no strobe is emitted after reset releases.
- Write capture:
  - While the synchronised chip_select and write_enable are both low, `armed` is set. data_bus_input and A0 are registered every such cycle, so the last value before the write_enable rise wins.
  - If chip_select goes high while write_enable is still low, armed clears and the write is dropped, with no strobe and no error.
  - Commit happens on the first synchronised cycle in which write_enable is high and armed is set.
  - If write_enable and chip_select rise in the same cycle, the write is valid.
- Latency: the strobe is asserted SYNC_STAGES+1 clocks after the pin-level write_enable rising edge. internal_data_bus updates in the same cycle as the strobe and holds until the next commit.
- Decode at commit (d = latched bits [7:0]):
  - A0=0, d[4]=1: write_ICW1. Always accepted in any state. Captures SNGL, IC4 and LTIM, clears init_done, and sets FSM to WAIT_ICW2.
  - A0=1 in WAIT_ICW2: write_ICW2. Next state is WAIT_ICW3 if !single_mode, else WAIT_ICW4 if icw4_needed, else READY.
  - A0=1 in WAIT_ICW3: write_ICW3. Next state is WAIT_ICW4 if icw4_needed, else READY.
  - A0=1 in WAIT_ICW4: write_ICW4. Next state is READY.
  - A0=1 in READY: write_OCW1.
  - A0=0, d[4]=0, d[3]=0 in READY: write_OCW2.
  - A0=0, d[4]=0, d[3]=1 in READY: write_OCW3.
  - Any A0=1 write in IDLE: no command strobe, protocol_error pulse, state unchanged.
  - Any A0=0, d[4]=0 write in IDLE or a WAIT state: no command strobe, protocol_error pulse, state unchanged.
- Exactly one of the seven command strobes (or protocol_error) pulses per committed write.
- Read and write overlap: if read_enable and write_enable are low in the same synchronised cycle with chip_select low:
  - the write proceeds;
  - read is forced 0 and read_start is suppressed;
  - protocol_error pulses once, on the first overlap cycle.
- read_start fires once per read access. A read held low for N cycles gives a single pulse. Reads never alter FSM state.
- Bits above [7] of data_bus_input pass through to internal_data_bus and are ignored by decode.

Test Plan:
- Reset, then SYNC_STAGES=2; write A0=0 0x13 (SNGL=1, IC4=1, LTIM=0), A0=1 0x20, A0=1 0x01 → strobes write_ICW1, write_ICW2, write_ICW4 in order, each 3 clocks after its write_enable rise. init_done=1; single_mode=1, icw4_needed=1.
- Cascade init: A0=0 0x10, A0=1 0x08, A0=1 0x04 → write_ICW1, write_ICW2, write_ICW3, then init_done=1 with no write_ICW4. Next A0=1 0xFF → write_OCW1, internal_data_bus=0xFF.
- After init: A0=0 0x20 → write_OCW2; A0=0 0x0B → write_OCW3. In READY, A0=0 0x10 → write_ICW1, init_done drops to 0.
- From reset: A0=1 0x55 → protocol_error only. A0=0 0x08 in WAIT_ICW2 → protocol_error, state stays WAIT_ICW2.
- Read low for 4 cycles with chip_select low → read high 4 cycles, one read_start. Write with chip_select raised before write_enable → no strobe.
- Overlapping read and write → read stays 0, protocol_error once, write strobe still emitted. Assert reset during a write → no strobe after release, all outputs 0.
